// File: rtl/descrack_sched_pkg.sv
// rtl/descrack_sched_pkg.sv - shared widths, job/result types and round-robin picker
package descrack_pkg;

    localparam int CT_W      = 64;
    localparam int K_W       = 56;
    localparam int T_W       = 20;
    localparam int ID_W      = 12;
    localparam int RES_W     = K_W + T_W + ID_W;
    localparam int MAX_CORES = 16;
    localparam int PTR_W     = 4;

    typedef struct packed {
        logic [CT_W-1:0] ct;
        logic [CT_W-1:0] r;
        logic [T_W-1:0]  t;
        logic [ID_W-1:0] id;
    } job_t;

    typedef struct packed {
        logic [K_W-1:0]  k;
        logic [T_W-1:0]  t;
        logic [ID_W-1:0] id;
    } res_t;

    typedef struct packed {
        logic             valid;
        logic [PTR_W-1:0] idx;
    } rr_pick_t;

    // First set bit of mask at or after ptr, wrapping at n; lowest offset wins.
    function automatic rr_pick_t rr_pick(input logic [MAX_CORES-1:0] mask,
                                         input logic [PTR_W-1:0] ptr,
                                         input int n);
        rr_pick_t       pick;
        logic [PTR_W:0] sum;
        pick = '0;
        for (int k = MAX_CORES - 1; k >= 0; k--) begin
            if (k < n) begin
                sum = {1'b0, ptr} + (PTR_W+1)'(k);
                if (sum >= (PTR_W+1)'(n)) begin
                    sum = sum - (PTR_W+1)'(n);
                end
                if (mask[sum[PTR_W-1:0]]) begin
                    pick.valid = 1'b1;
                    pick.idx   = sum[PTR_W-1:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/descrack_sched_if.sv
// rtl/descrack_sched_if.sv - upstream, per-core and downstream signal bundle of the scheduler
interface descrack_sched_if #(
    parameter int NUM_CORES = 4
);
    import descrack_pkg::*;

    logic                      clken;
    logic [CT_W-1:0]           in_ct;
    logic [CT_W-1:0]           in_r;
    logic [T_W-1:0]            in_t;
    logic [ID_W-1:0]           in_id;
    logic                      in_empty;
    logic                      in_rd;
    logic [NUM_CORES*CT_W-1:0] core_ct;
    logic [NUM_CORES*CT_W-1:0] core_r;
    logic [NUM_CORES*T_W-1:0]  core_t;
    logic [NUM_CORES*ID_W-1:0] core_id;
    logic [NUM_CORES-1:0]      core_empty;
    logic [NUM_CORES-1:0]      core_rd;
    logic [NUM_CORES*K_W-1:0]  core_k;
    logic [NUM_CORES*T_W-1:0]  core_rt;
    logic [NUM_CORES*ID_W-1:0] core_rid;
    logic [NUM_CORES-1:0]      core_wr;
    logic [K_W-1:0]            out_k;
    logic [T_W-1:0]            out_t;
    logic [ID_W-1:0]           out_id;
    logic                      out_wr;
    logic                      out_full;
    logic                      idle;
    logic                      err_overflow;

    modport master (
        output clken, in_ct, in_r, in_t, in_id, in_empty, core_rd,
               core_k, core_rt, core_rid, core_wr, out_full,
        input  in_rd, core_ct, core_r, core_t, core_id, core_empty,
               out_k, out_t, out_id, out_wr, idle, err_overflow
    );

    modport slave (
        input  clken, in_ct, in_r, in_t, in_id, in_empty, core_rd,
               core_k, core_rt, core_rid, core_wr, out_full,
        output in_rd, core_ct, core_r, core_t, core_id, core_empty,
               out_k, out_t, out_id, out_wr, idle, err_overflow
    );

endinterface

// File: rtl/descrack_sched_res_fifo.sv
// rtl/descrack_sched_res_fifo.sv - per-core FWFT result FIFO
module sched_res_fifo
    import descrack_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  res_t din,
    input  logic pop,
    output res_t dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    res_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is dropped; the scheduler flags it.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage write; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/descrack_sched.sv
// rtl/descrack_sched.sv - job fan-out to descrack cores with credit-bounded result fan-in
module descrack_sched
    import descrack_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int RES_DEPTH = 4,
    parameter int CW        = 3
) (
    input logic             clk,
    input logic             rst,
    descrack_sched_if.slave bus
);
    logic [NUM_CORES-1:0] slot_valid;
    job_t                 slot [NUM_CORES];
    logic [CW-1:0]        credit [NUM_CORES];
    logic [PTR_W-1:0]     issue_ptr;
    logic [PTR_W-1:0]     drain_ptr;
    logic                 in_rd_q;
    logic                 out_wr_q;
    logic                 err_q;
    res_t                 out_q;
    job_t                 in_job;
    res_t                 drain_data;
    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] issue_sel;
    logic [NUM_CORES-1:0] drain_sel;
    logic [NUM_CORES-1:0] fifo_push;
    logic [NUM_CORES-1:0] fifo_full;
    logic [NUM_CORES-1:0] fifo_empty;
    res_t                 fifo_din  [NUM_CORES];
    res_t                 fifo_dout [NUM_CORES];
    rr_pick_t             iss;
    rr_pick_t             drn;
    logic                 do_issue;
    logic                 do_drain;
    logic                 credits_zero;

    assign in_job = {bus.in_ct, bus.in_r, bus.in_t, bus.in_id};

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        assign bus.core_ct[i*CT_W +: CT_W] = slot[i].ct;
        assign bus.core_r[i*CT_W +: CT_W]  = slot[i].r;
        assign bus.core_t[i*T_W +: T_W]    = slot[i].t;
        assign bus.core_id[i*ID_W +: ID_W] = slot[i].id;
        assign fifo_din[i]  = {bus.core_k[i*K_W +: K_W], bus.core_rt[i*T_W +: T_W],
                               bus.core_rid[i*ID_W +: ID_W]};
        assign fifo_push[i] = bus.clken & bus.core_wr[i];

        sched_res_fifo #(.DEPTH(RES_DEPTH)) u_res_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (fifo_push[i]),
            .din   (fifo_din[i]),
            .pop   (drain_sel[i]),
            .dout  (fifo_dout[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i])
        );
    end

    // Pick the issue target and drain source; in_rd_q blocks issue until FWFT data refreshes.
    always_comb begin
        eligible     = '0;
        issue_sel    = '0;
        drain_sel    = '0;
        drain_data   = '0;
        credits_zero = 1'b1;
        for (int i = 0; i < NUM_CORES; i++) begin
            eligible[i] = ~slot_valid[i] & (credit[i] < CW'(RES_DEPTH));
            if (credit[i] != '0) credits_zero = 1'b0;
        end
        iss      = rr_pick(MAX_CORES'(eligible), issue_ptr, NUM_CORES);
        drn      = rr_pick(MAX_CORES'(~fifo_empty), drain_ptr, NUM_CORES);
        do_issue = bus.clken & ~bus.in_empty & ~in_rd_q & iss.valid;
        do_drain = bus.clken & ~bus.out_full & drn.valid;
        for (int i = 0; i < NUM_CORES; i++) begin
            issue_sel[i] = do_issue & (iss.idx == PTR_W'(i));
            drain_sel[i] = do_drain & (drn.idx == PTR_W'(i));
            if (drain_sel[i]) drain_data = fifo_dout[i];
        end
    end

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_CORES - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Slot, credit, pointer and output-register state; pulses self-clear every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
            issue_ptr  <= '0;
            drain_ptr  <= '0;
            in_rd_q    <= 1'b0;
            out_wr_q   <= 1'b0;
            out_q      <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) credit[i] <= '0;
        end else begin
            in_rd_q  <= 1'b0;
            out_wr_q <= 1'b0;
            if (bus.clken) begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (bus.core_rd[i]) begin
                        if (slot_valid[i]) slot_valid[i] <= 1'b0;
                        else               err_q <= 1'b1;
                    end
                    if (issue_sel[i]) slot_valid[i] <= 1'b1;
                    if (fifo_push[i] && fifo_full[i]) err_q <= 1'b1;
                    if (issue_sel[i] && !drain_sel[i]) begin
                        credit[i] <= credit[i] + CW'(1);
                    end else if (drain_sel[i] && !issue_sel[i]) begin
                        if (credit[i] == '0) err_q <= 1'b1;
                        else                 credit[i] <= credit[i] - CW'(1);
                    end
                end
                if (do_issue) begin
                    in_rd_q   <= 1'b1;
                    issue_ptr <= next_ptr(iss.idx);
                end
                if (do_drain) begin
                    out_q     <= drain_data;
                    out_wr_q  <= 1'b1;
                    drain_ptr <= next_ptr(drn.idx);
                end
            end
        end
    end

    // Staged job payload; no reset needed since core_empty guards it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (issue_sel[i]) slot[i] <= in_job;
        end
    end

    assign bus.in_rd        = in_rd_q;
    assign bus.out_wr       = out_wr_q;
    assign bus.out_k        = out_q.k;
    assign bus.out_t        = out_q.t;
    assign bus.out_id       = out_q.id;
    assign bus.core_empty   = ~slot_valid;
    assign bus.err_overflow = err_q;
    assign bus.idle         = bus.in_empty & ~|slot_valid & credits_zero;

endmodule

// File: tb/tb_descrack_sched.sv
// tb/tb_descrack_sched.sv - randomized bench for descrack_sched against a queue-based model
module tb_descrack_sched;
    import descrack_pkg::*;

    localparam int NC = 4;
    localparam int RD = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    descrack_sched_if #(.NUM_CORES(NC)) bus ();

    descrack_sched #(.NUM_CORES(NC), .RES_DEPTH(RD), .CW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model state: upstream queue, staged slots, per-core pending work and result queues.
    job_t  up_q[$];
    job_t  m_slot[NC];
    bit    m_sv[NC];
    int    m_age[NC];
    int    m_wait[NC];
    int    m_cred[NC];
    res_t  m_res[NC][$];
    job_t  m_pend[NC][$];
    int    m_iptr, m_dptr;
    bit    m_in_rd, m_out_wr, m_err;
    res_t  m_out;

    int    pop_rand, wr_pct, full_pct, clken_pct, feed_pct;
    bit    bad_rd1;
    int    next_id = 1;
    int    issue_cores[$];
    int    rd_pulses, out_pulses;
    logic  prev_in_rd;
    logic [NC-1:0] prev_empty;
    int    exp_fill[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_job();
        job_t j;
        j.ct = {$urandom(), $urandom()};
        j.r  = {$urandom(), $urandom()};
        j.t  = T_W'($urandom());
        j.id = ID_W'(next_id);
        next_id++;
        up_q.push_back(j);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_sv[i]   = 1'b0;
            m_age[i]  = 0;
            m_wait[i] = 0;
            m_cred[i] = 0;
            m_res[i].delete();
            m_pend[i].delete();
        end
        m_iptr   = 0;
        m_dptr   = 0;
        m_in_rd  = 1'b0;
        m_out_wr = 1'b0;
        m_err    = 1'b0;
        m_out    = '0;
    endtask

    task automatic check_outputs();
        logic [NC-1:0] exp_empty;
        bit            exp_idle;
        exp_idle = bus.in_empty;
        for (int i = 0; i < NC; i++) begin
            exp_empty[i] = ~m_sv[i];
            if (m_sv[i] || m_cred[i] != 0) exp_idle = 1'b0;
        end
        check("in_rd", bus.in_rd, m_in_rd);
        check("out_wr", bus.out_wr, m_out_wr);
        if (m_out_wr) begin
            check("out_k", bus.out_k, m_out.k);
            check("out_t", bus.out_t, m_out.t);
            check("out_id", bus.out_id, m_out.id);
        end
        check("core_empty", bus.core_empty, exp_empty);
        for (int i = 0; i < NC; i++) begin
            if (m_sv[i]) begin
                check("core_id", bus.core_id[i*ID_W +: ID_W], m_slot[i].id);
                check("core_ct", bus.core_ct[i*CT_W +: CT_W], m_slot[i].ct);
                check("core_r", bus.core_r[i*CT_W +: CT_W], m_slot[i].r);
                check("core_t", bus.core_t[i*T_W +: T_W], m_slot[i].t);
            end
        end
        check("idle", bus.idle, exp_idle);
        check("err", bus.err_overflow, m_err);
        if (prev_in_rd === 1'b1) check("in_rd_gap", bus.in_rd, 0);
        if (bus.in_rd === 1'b1) begin
            rd_pulses++;
            for (int i = 0; i < NC; i++) begin
                if (prev_empty[i] && !bus.core_empty[i]) issue_cores.push_back(i);
            end
        end
        if (bus.out_wr === 1'b1) out_pulses++;
        prev_in_rd = bus.in_rd;
        prev_empty = bus.core_empty;
    endtask

    // Drive one cycle of stimulus, advance the model across the edge, then compare.
    task automatic cycle(input bit do_rst);
        logic [NC-1:0] rd_v, wr_v;
        res_t          wr_r[NC];
        job_t          j;
        int            ic, dc, c;
        if (!do_rst && $urandom_range(99) < feed_pct) add_job();
        rst          = do_rst;
        bus.clken    = do_rst || ($urandom_range(99) < clken_pct);
        bus.out_full = ($urandom_range(99) < full_pct);
        bus.in_empty = (up_q.size() == 0);
        j = (up_q.size() > 0) ? up_q[0] : '0;
        bus.in_ct    = j.ct;
        bus.in_r     = j.r;
        bus.in_t     = j.t;
        bus.in_id    = j.id;
        rd_v = '0;
        wr_v = '0;
        bus.core_k   = '0;
        bus.core_rt  = '0;
        bus.core_rid = '0;
        for (int i = 0; i < NC; i++) begin
            wr_r[i] = '0;
            if (bus.clken && !do_rst) begin
                if (m_sv[i] && m_age[i] >= m_wait[i]) rd_v[i] = 1'b1;
                if (bad_rd1 && i == 1 && !m_sv[i]) rd_v[i] = 1'b1;
                if (m_pend[i].size() > 0 && $urandom_range(99) < wr_pct) begin
                    wr_v[i]    = 1'b1;
                    wr_r[i].k  = K_W'({$urandom(), $urandom()});
                    wr_r[i].t  = m_pend[i][0].t;
                    wr_r[i].id = m_pend[i][0].id;
                    void'(m_pend[i].pop_front());
                    bus.core_k[i*K_W +: K_W]    = wr_r[i].k;
                    bus.core_rt[i*T_W +: T_W]   = wr_r[i].t;
                    bus.core_rid[i*ID_W +: ID_W] = wr_r[i].id;
                end
            end
        end
        bus.core_rd = rd_v;
        bus.core_wr = wr_v;

        if (do_rst) begin
            model_reset();
        end else begin
            ic = -1;
            dc = -1;
            if (bus.clken) begin
                if (!bus.in_empty && !m_in_rd) begin
                    for (int k = 0; k < NC; k++) begin
                        c = (m_iptr + k) % NC;
                        if (ic < 0 && !m_sv[c] && m_cred[c] < RD) ic = c;
                    end
                end
                if (!bus.out_full) begin
                    for (int k = 0; k < NC; k++) begin
                        c = (m_dptr + k) % NC;
                        if (dc < 0 && m_res[c].size() > 0) dc = c;
                    end
                end
                for (int i = 0; i < NC; i++) begin
                    if (m_sv[i]) m_age[i]++;
                    if (rd_v[i]) begin
                        if (m_sv[i]) begin
                            m_pend[i].push_back(m_slot[i]);
                            m_sv[i] = 1'b0;
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                end
                if (ic >= 0) begin
                    m_slot[ic] = up_q.pop_front();
                    m_sv[ic]   = 1'b1;
                    m_age[ic]  = 0;
                    m_wait[ic] = pop_rand ? int'($urandom_range(4)) : 2;
                    m_cred[ic]++;
                    m_iptr = (ic + 1) % NC;
                end
                if (dc >= 0) begin
                    m_out  = m_res[dc].pop_front();
                    m_dptr = (dc + 1) % NC;
                    if (m_cred[dc] == 0) m_err = 1'b1;
                    else                 m_cred[dc]--;
                end
                for (int i = 0; i < NC; i++) begin
                    if (wr_v[i]) begin
                        if (m_res[i].size() >= RD) m_err = 1'b1;
                        else                       m_res[i].push_back(wr_r[i]);
                    end
                end
            end
            m_in_rd  = (ic >= 0);
            m_out_wr = (dc >= 0);
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst          = 1'b1;
        bus.clken    = 1'b1;
        bus.in_ct    = '0;
        bus.in_r     = '0;
        bus.in_t     = '0;
        bus.in_id    = '0;
        bus.in_empty = 1'b1;
        bus.core_rd  = '0;
        bus.core_k   = '0;
        bus.core_rt  = '0;
        bus.core_rid = '0;
        bus.core_wr  = '0;
        bus.out_full = 1'b0;
        prev_in_rd   = 1'b0;
        prev_empty   = '1;
        pop_rand = 0; wr_pct = 0; full_pct = 0; clken_pct = 100; feed_pct = 0; bad_rd1 = 1'b0;
        rd_pulses = 0; out_pulses = 0;
        model_reset();

        cycle(1);
        cycle(1);
        check("rst_core_empty", bus.core_empty, 4'hF);
        check("rst_in_rd", bus.in_rd, 0);
        check("rst_out_wr", bus.out_wr, 0);
        check("rst_out_k", bus.out_k, 0);
        check("rst_idle", bus.idle, 1);
        check("rst_err", bus.err_overflow, 0);

        // Fill order: 8 jobs, fixed pop delay, no results yet.
        for (int i = 0; i < 8; i++) add_job();
        issue_cores.delete();
        rd_pulses = 0;
        repeat (24) cycle(0);
        check("fill_count", rd_pulses, 8);
        for (int i = 0; i < 8; i++) begin
            check("fill_core", (i < issue_cores.size()) ? issue_cores[i] : -1, exp_fill[i]);
        end

        // Every core returns its results in the same cycles.
        wr_pct = 100;
        repeat (16) cycle(0);
        check("sim_idle", bus.idle, 1);

        // Credit stall: results withheld, only NC*RD jobs may be issued.
        wr_pct = 0;
        for (int i = 0; i < 20; i++) add_job();
        rd_pulses = 0;
        repeat (80) cycle(0);
        check("stall_issued", rd_pulses, NC * RD);
        check("stall_idle", bus.idle, 0);
        wr_pct = 100;
        repeat (60) cycle(0);
        check("stall_recover_idle", bus.idle, 1);

        // Downstream backpressure holds results intact.
        full_pct = 100;
        for (int i = 0; i < 3; i++) add_job();
        out_pulses = 0;
        repeat (25) cycle(0);
        check("bp_no_out", out_pulses, 0);
        full_pct = 0;
        repeat (10) cycle(0);
        check("bp_out_count", out_pulses, 3);

        // Random traffic with a reset in the middle.
        pop_rand = 1; wr_pct = 40; full_pct = 30; clken_pct = 85; feed_pct = 30;
        repeat (300) cycle(0);
        cycle(1);
        check("rstmid_core_empty", bus.core_empty, 4'hF);
        check("rstmid_out_wr", bus.out_wr, 0);
        repeat (300) cycle(0);
        feed_pct = 0; full_pct = 0; clken_pct = 100; wr_pct = 100;
        repeat (150) cycle(0);
        check("final_idle", bus.idle, 1);

        // Pop of an empty slot raises a sticky error.
        bad_rd1 = 1'b1;
        cycle(0);
        bad_rd1 = 1'b0;
        repeat (5) cycle(0);
        check("err_sticky", bus.err_overflow, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
